// File: rtl/lmg_reader.sv
// Drains 160-bit move words from the generator FIFO and presents each
// valid 19-bit slot as a move on a valid/ready port, counting accepted moves.
module lmg_reader #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             gen_done,
    input  logic [159:0]     fifoOut,
    input  logic             fifoEmpty,
    output logic             rden,
    output logic             mv_valid,
    input  logic             mv_ready,
    output logic [6:0]       mv_flags,
    output logic [5:0]       mv_from,
    output logic [5:0]       mv_to,
    output logic [CNT_W-1:0] mv_count,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SCAN,
        S_FIN
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [151:0]       r_word;
    logic [2:0]         r_idx;
    logic [CNT_W-1:0]   r_count;
    logic               r_arm;
    logic [18:0]        w_slot;
    logic               w_slot_ok;
    logic               w_adv;
    logic               w_take;
    logic               w_clr;
    logic               w_unused_pad;

    assign w_unused_pad = ^fifoOut[159:152];

    // Slot 0 sits in the most significant bits of the word.
    always_comb begin
        w_slot = '0;
        for (int k = 0; k < 8; k++) begin
            if (r_idx == 3'(k)) begin
                w_slot = r_word[151-19*k -: 19];
            end
        end
    end

    assign w_slot_ok = !w_slot[18];
    assign mv_valid  = (r_state == S_SCAN) && w_slot_ok;
    assign mv_flags  = w_slot[18:12];
    assign mv_from   = w_slot[11:6];
    assign mv_to     = w_slot[5:0];
    assign mv_count  = r_count;
    assign w_take    = mv_valid && mv_ready;
    assign w_adv     = (r_state == S_SCAN) && (!w_slot_ok || mv_ready);

    always_comb begin
        w_next = r_state;
        rden   = 1'b0;
        done   = 1'b0;
        w_clr  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_FETCH;
                    w_clr  = 1'b1;
                end
            end
            S_FETCH: begin
                // Empty+done must be seen twice so an in-flight write is not lost.
                if (!fifoEmpty) begin
                    rden   = 1'b1;
                    w_next = S_LOAD;
                end else if (gen_done && r_arm) begin
                    w_next = S_FIN;
                end
            end
            S_LOAD: begin
                w_next = S_SCAN;
            end
            S_SCAN: begin
                if (w_adv && (r_idx == 3'd7)) begin
                    w_next = S_FETCH;
                end
            end
            S_FIN: begin
                done = 1'b1;
                if (start) begin
                    w_next = S_FETCH;
                    w_clr  = 1'b1;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_word  <= '0;
            r_idx   <= '0;
            r_count <= '0;
            r_arm   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_arm   <= (r_state == S_FETCH) && fifoEmpty && gen_done;
            if (r_state == S_LOAD) begin
                r_word <= fifoOut[151:0];
                r_idx  <= '0;
            end else if (w_adv) begin
                r_idx <= r_idx + 3'd1;
            end
            if (w_clr) begin
                r_count <= '0;
            end else if (w_take && (r_count != {CNT_W{1'b1}})) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lmg_reader.sv
// Bench for lmg_reader: FIFO model, move scoreboard, vector table
// and hand-written multi-cycle sequences.
module tb_lmg_reader;

    typedef logic [7:0][18:0] slots_t;
    typedef struct {
        slots_t s;
        int     exp_cnt;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         gen_done = 1'b0;
    logic         mv_ready = 1'b1;
    logic [159:0] fifoOut = '0;
    logic         fifoEmpty;
    logic         rden;
    logic         mv_valid;
    logic         done;
    logic [6:0]   mv_flags;
    logic [5:0]   mv_from;
    logic [5:0]   mv_to;
    logic [7:0]   mv_count;

    logic [159:0] mem [64];
    int           wr_ptr = 0;
    int           rd_ptr = 0;
    logic [18:0]  sb [$];
    logic [18:0]  m_exp;
    int           checks = 0;
    int           errors = 0;
    vec_t         vecs [5];

    lmg_reader #(.CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .gen_done  (gen_done),
        .fifoOut   (fifoOut),
        .fifoEmpty (fifoEmpty),
        .rden      (rden),
        .mv_valid  (mv_valid),
        .mv_ready  (mv_ready),
        .mv_flags  (mv_flags),
        .mv_from   (mv_from),
        .mv_to     (mv_to),
        .mv_count  (mv_count),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Non-showahead FIFO: data appears the cycle after rden.
    assign fifoEmpty = (rd_ptr == wr_ptr);
    always @(posedge clk) begin
        if (rden) begin
            fifoOut <= mem[rd_ptr % 64];
            rd_ptr  <= rd_ptr + 1;
        end
    end

    always @(negedge clk) begin
        if (reset && rden && fifoEmpty) begin
            errors++;
            $display("FAIL rden_when_empty: rden=%0b with fifoEmpty=1", rden);
        end
        if (reset && mv_valid && mv_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_move: got %h required none",
                         {mv_flags, mv_from, mv_to});
            end else begin
                m_exp = sb.pop_front();
                if ({mv_flags, mv_from, mv_to} !== m_exp) begin
                    errors++;
                    $display("FAIL move: got %h required %h",
                             {mv_flags, mv_from, mv_to}, m_exp);
                end
            end
        end
    end

    function automatic logic [159:0] build(input slots_t s);
        logic [159:0] w;
        w = '0;
        w[159:152] = 8'hA5;
        for (int k = 0; k < 8; k++) begin
            w[151-19*k -: 19] = s[k];
        end
        return w;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic push_word(input slots_t s);
        mem[wr_ptr % 64] = build(s);
        wr_ptr++;
        for (int k = 0; k < 8; k++) begin
            if (!s[k][18]) sb.push_back(s[k]);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        #2;
        chk("rst_rden", rden, 0);
        chk("rst_valid", mv_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_count", mv_count, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_reached", done, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          first;
        int          n;
        logic [18:0] rec;

        for (int k = 0; k < 8; k++) begin
            vecs[0].s[k] = {7'h00, 3'(k), 3'd1, 3'(k), 3'd2};
            vecs[2].s[k] = (k % 2 == 0) ? {7'h3F, 6'(k), 6'(63 - k)}
                                        : {7'h7F, 6'(k), 6'(63 - k)};
            vecs[3].s[k] = {7'h40, 6'(k), 6'(k)};
            vecs[4].s[k] = {7'h41 + 7'(k), 6'(k), 6'(k)};
            vecs[1].s[k] = {7'h40, 6'o00, 6'o00};
        end
        vecs[1].s[0] = {7'h00, 6'o10, 6'o02};
        vecs[1].s[1] = {7'h00, 6'o10, 6'o22};
        vecs[1].s[2] = {7'h00, 6'o60, 6'o52};
        vecs[1].s[3] = {7'h00, 6'o60, 6'o72};
        vecs[4].s[7] = {7'h15, 6'o77, 6'o00};
        vecs[0].exp_cnt = 8;
        vecs[1].exp_cnt = 4;
        vecs[2].exp_cnt = 4;
        vecs[3].exp_cnt = 0;
        vecs[4].exp_cnt = 1;

        for (int i = 0; i < 5; i++) begin
            do_reset();
            gen_done = 1'b1;
            mv_ready = 1'b1;
            push_word(vecs[i].s);
            repeat (2) begin
                @(negedge clk);
                chk($sformatf("vec%0d_no_rden", i), rden, 0);
            end
            @(posedge clk);
            #1;
            pulse_start();
            wait_done(200);
            chk($sformatf("vec%0d_count", i), mv_count, vecs[i].exp_cnt);
            chk($sformatf("vec%0d_sb_empty", i), sb.size(), 0);
        end

        // Start-to-first-move latency and single-cycle rden.
        do_reset();
        gen_done = 1'b1;
        push_word(vecs[0].s);
        @(posedge clk);
        #1;
        start = 1'b1;
        first = -1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("lat_rden_fetch", rden, 1);
        for (int c = 3; c <= 7; c++) begin
            @(posedge clk);
            #1;
            if (c == 3) chk("lat_rden_load", rden, 0);
            if (mv_valid && first < 0) first = c;
        end
        chk("lat_first_valid", first, 4);
        wait_done(100);
        chk("lat_count", mv_count, 8);

        // Consumer back-pressure on slot 0.
        do_reset();
        gen_done = 1'b1;
        mv_ready = 1'b0;
        push_word(vecs[0].s);
        pulse_start();
        n = 0;
        while (!mv_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("stall_valid", mv_valid, 1);
        rec = {mv_flags, mv_from, mv_to};
        chk("stall_slot0", rec, {7'h00, 6'o01, 6'o02});
        repeat (5) begin
            @(negedge clk);
            chk("stall_hold", {mv_valid, mv_flags, mv_from, mv_to},
                {1'b1, rec});
            chk("stall_count", mv_count, 0);
            chk("stall_rden", rden, 0);
        end
        @(posedge clk);
        #1;
        mv_ready = 1'b1;
        wait_done(100);
        chk("stall_final_count", mv_count, 8);

        // Three words, gen_done rises as the last word lands.
        do_reset();
        gen_done = 1'b0;
        push_word(vecs[0].s);
        push_word(vecs[0].s);
        pulse_start();
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("multi_first_two", sb.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("multi_not_done", done, 0);
        push_word(vecs[1].s);
        gen_done = 1'b1;
        wait_done(100);
        chk("multi_count", mv_count, 20);
        chk("multi_sb_empty", sb.size(), 0);

        // Reset while presenting slot 3.
        do_reset();
        gen_done = 1'b0;
        push_word(vecs[0].s);
        pulse_start();
        n = 0;
        while (!(mv_valid && mv_from == 6'o31) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rmid_at_slot3", {mv_valid, mv_from}, {1'b1, 6'o31});
        #1;
        reset = 1'b0;
        #1;
        chk("rmid_valid", mv_valid, 0);
        chk("rmid_count", mv_count, 0);
        chk("rmid_rden", rden, 0);
        chk("rmid_done", done, 0);
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        gen_done = 1'b1;
        @(posedge clk);
        #1;
        pulse_start();
        wait_done(50);
        chk("rmid_after_count", mv_count, 0);

        // One empty+done FETCH cycle, then a word arrives.
        do_reset();
        gen_done = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("glitch_not_done", done, 0);
        push_word(vecs[2].s);
        #1;
        chk("glitch_rden", rden, 1);
        wait_done(100);
        chk("glitch_count", mv_count, 4);
        chk("glitch_sb_empty", sb.size(), 0);

        // Counter saturation, then restart from FIN clears it.
        do_reset();
        gen_done = 1'b1;
        for (int w = 0; w < 33; w++) push_word(vecs[0].s);
        pulse_start();
        wait_done(1000);
        chk("sat_count", mv_count, 255);
        chk("sat_sb_empty", sb.size(), 0);
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("restart_count", mv_count, 0);
        chk("restart_done", done, 0);
        wait_done(20);
        chk("restart_final", mv_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
